// File: rtl/loongarch_exc_pkg.sv
// Shared exception codes and FSM state encodings for the writeback commit unit.
package loongarch_exc_pkg;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_BRK = 6'h0C;
   localparam logic [5:0] ECODE_INE = 6'h0D;

   localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_WAIT_ACK = 1'b1;

endpackage

// File: rtl/wb_exc_commit_if.sv
// MEM-to-WB instruction handshake and payload bus.
interface wb_exc_commit_if;

   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic [31:0] ms_vaddr;
   logic        ms_exc_adef;
   logic        ms_exc_ine;
   logic        ms_exc_sys;
   logic        ms_exc_brk;
   logic        ms_exc_ale;
   logic        ms_ertn;
   logic        ms_rf_we;

   modport master (
      output ms_to_ws_valid, ms_pc, ms_vaddr, ms_exc_adef, ms_exc_ine,
             ms_exc_sys, ms_exc_brk, ms_exc_ale, ms_ertn, ms_rf_we,
      input  ws_allowin
   );

   modport slave (
      input  ms_to_ws_valid, ms_pc, ms_vaddr, ms_exc_adef, ms_exc_ine,
             ms_exc_sys, ms_exc_brk, ms_exc_ale, ms_ertn, ms_rf_we,
      output ws_allowin
   );

endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: INT > ADEF > INE > SYS > BRK > ALE.
module exc_prio_enc
   import loongarch_exc_pkg::*;
(
   input  logic       i_int,
   input  logic       i_adef,
   input  logic       i_ine,
   input  logic       i_sys,
   input  logic       i_brk,
   input  logic       i_ale,
   output logic       o_excAny,
   output logic [5:0] o_ecode,
   output logic [8:0] o_esubcode,
   output logic       o_isAle
);

   // First matching source wins; codes stay 0 when nothing is raised.
   always_comb begin
      o_ecode    = 6'h00;
      o_esubcode = 9'd0;
      o_isAle    = 1'b0;
      if (i_int) begin
         o_ecode = ECODE_INT;
      end else if (i_adef) begin
         o_ecode    = ECODE_ADE;
         o_esubcode = ESUBCODE_ADEF;
      end else if (i_ine) begin
         o_ecode = ECODE_INE;
      end else if (i_sys) begin
         o_ecode = ECODE_SYS;
      end else if (i_brk) begin
         o_ecode = ECODE_BRK;
      end else if (i_ale) begin
         o_ecode = ECODE_ALE;
         o_isAle = 1'b1;
      end
   end

   assign o_excAny = i_int | i_adef | i_ine | i_sys | i_brk | i_ale;

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback exception commit: resolves the WB instruction's exception, strobes
// the CSR file, flushes the pipe and holds until fetch takes the redirect.
module wb_exc_commit
   import loongarch_exc_pkg::*;
#(
   parameter int EENTRY_ALIGN = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   wb_exc_commit_if.slave       ms,
   input  logic                 csr_int_pending,
   input  logic [31:0]          csr_eentry,
   input  logic [31:0]          csr_era,
   input  logic                 fs_redirect_ack,
   output logic                 wb_ex,
   output logic [5:0]           wb_ecode,
   output logic [8:0]           wb_esubcode,
   output logic [31:0]          wb_pc,
   output logic [31:0]          wb_vaddr,
   output logic                 eret_flush,
   output logic                 ws_flush,
   output logic [31:0]          flush_pc,
   output logic                 ws_rf_we
);

   logic [0:0]  r_state;
   logic        r_wsValid;
   logic [31:0] r_wsPc;
   logic [31:0] r_wsVaddr;
   logic        r_wsAdef, r_wsIne, r_wsSys, r_wsBrk, r_wsAle;
   logic        r_wsErtn;
   logic        r_wsRfWe;
   logic [31:0] r_flushPc;

   logic        w_run;
   logic        w_excAny;
   logic [5:0]  w_ecode;
   logic [8:0]  w_esubcode;
   logic        w_isAle;
   logic        w_commit;
   logic [31:0] w_eentryMask;
   logic [31:0] w_target;

   exc_prio_enc u_prio (
      .i_int      (csr_int_pending),
      .i_adef     (r_wsAdef),
      .i_ine      (r_wsIne),
      .i_sys      (r_wsSys),
      .i_brk      (r_wsBrk),
      .i_ale      (r_wsAle),
      .o_excAny   (w_excAny),
      .o_ecode    (w_ecode),
      .o_esubcode (w_esubcode),
      .o_isAle    (w_isAle)
   );

   assign w_run         = (r_state == ST_RUN);
   assign ms.ws_allowin = w_run;

   assign wb_ex       = w_run && r_wsValid && w_excAny;
   assign eret_flush  = w_run && r_wsValid && r_wsErtn && !w_excAny;
   assign ws_rf_we    = w_run && r_wsValid && r_wsRfWe && !w_excAny;
   assign wb_ecode    = wb_ex ? w_ecode : 6'h00;
   assign wb_esubcode = wb_ex ? w_esubcode : 9'd0;
   assign wb_pc       = r_wsPc;
   assign wb_vaddr    = (wb_ex && w_isAle) ? r_wsVaddr : r_wsPc;

   assign w_commit     = wb_ex || eret_flush;
   assign ws_flush     = w_commit;
   assign w_eentryMask = ~((32'h1 << EENTRY_ALIGN) - 32'h1);
   assign w_target     = wb_ex ? (csr_eentry & w_eentryMask) : csr_era;
   assign flush_pc     = w_commit ? w_target : (w_run ? 32'h0 : r_flushPc);

   // Control: a commit drops the WB slot (whatever MEM offered that cycle is
   // being flushed) and parks the FSM until fetch acknowledges the redirect.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_wsValid <= 1'b0;
         r_flushPc <= 32'h0;
      end else if (w_run) begin
         if (w_commit) begin
            r_state   <= ST_WAIT_ACK;
            r_wsValid <= 1'b0;
            r_flushPc <= w_target;
         end else begin
            r_wsValid <= ms.ms_to_ws_valid;
         end
      end else begin
         r_wsValid <= 1'b0;
         if (fs_redirect_ack) begin
            r_state <= ST_RUN;
         end
      end
   end

   // Payload is only meaningful alongside r_wsValid.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wsPc    <= 32'h0;
         r_wsVaddr <= 32'h0;
         r_wsAdef  <= 1'b0;
         r_wsIne   <= 1'b0;
         r_wsSys   <= 1'b0;
         r_wsBrk   <= 1'b0;
         r_wsAle   <= 1'b0;
         r_wsErtn  <= 1'b0;
         r_wsRfWe  <= 1'b0;
      end else if (ms.ms_to_ws_valid && w_run) begin
         r_wsPc    <= ms.ms_pc;
         r_wsVaddr <= ms.ms_vaddr;
         r_wsAdef  <= ms.ms_exc_adef;
         r_wsIne   <= ms.ms_exc_ine;
         r_wsSys   <= ms.ms_exc_sys;
         r_wsBrk   <= ms.ms_exc_brk;
         r_wsAle   <= ms.ms_exc_ale;
         r_wsErtn  <= ms.ms_ertn;
         r_wsRfWe  <= ms.ms_rf_we;
      end
   end

endmodule

// File: tb/tb_wb_exc_commit.sv
// Directed-vector bench for wb_exc_commit with hand-computed expectations.
module tb_wb_exc_commit;

   logic        clock;
   logic        reset;
   logic        csr_int_pending;
   logic [31:0] csr_eentry;
   logic [31:0] csr_era;
   logic        fs_redirect_ack;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc;
   logic [31:0] wb_vaddr;
   logic        eret_flush;
   logic        ws_flush;
   logic [31:0] flush_pc;
   logic        ws_rf_we;

   int vectors;
   int miscompares;

   wb_exc_commit_if bus ();

   wb_exc_commit #(.EENTRY_ALIGN(6)) dut (
      .clock           (clock),
      .reset           (reset),
      .ms              (bus),
      .csr_int_pending (csr_int_pending),
      .csr_eentry      (csr_eentry),
      .csr_era         (csr_era),
      .fs_redirect_ack (fs_redirect_ack),
      .wb_ex           (wb_ex),
      .wb_ecode        (wb_ecode),
      .wb_esubcode     (wb_esubcode),
      .wb_pc           (wb_pc),
      .wb_vaddr        (wb_vaddr),
      .eret_flush      (eret_flush),
      .ws_flush        (ws_flush),
      .flush_pc        (flush_pc),
      .ws_rf_we        (ws_rf_we)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clearMs();
      bus.ms_to_ws_valid = 1'b0;
      bus.ms_pc          = 32'h0;
      bus.ms_vaddr       = 32'h0;
      bus.ms_exc_adef    = 1'b0;
      bus.ms_exc_ine     = 1'b0;
      bus.ms_exc_sys     = 1'b0;
      bus.ms_exc_brk     = 1'b0;
      bus.ms_exc_ale     = 1'b0;
      bus.ms_ertn        = 1'b0;
      bus.ms_rf_we       = 1'b0;
   endtask

   // Presents one instruction for a single cycle; afterwards it sits in WB.
   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] vaddr,
                                input logic [4:0] flags, input logic ertn,
                                input logic rfWe);
      clearMs();
      bus.ms_to_ws_valid = 1'b1;
      bus.ms_pc          = pc;
      bus.ms_vaddr       = vaddr;
      {bus.ms_exc_adef, bus.ms_exc_ine, bus.ms_exc_sys,
       bus.ms_exc_brk, bus.ms_exc_ale} = flags;
      bus.ms_ertn        = ertn;
      bus.ms_rf_we       = rfWe;
      tick();
      clearMs();
   endtask

   // From the commit cycle: enter WAIT_ACK, then ack for one cycle.
   task automatic finishRedirect();
      tick();
      fs_redirect_ack = 1'b1;
      tick();
      fs_redirect_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vectors++;
      if (bus.ws_allowin !== 1'b1 || wb_ex !== 1'b0 || ws_flush !== 1'b0 ||
          eret_flush !== 1'b0 || ws_rf_we !== 1'b0 || flush_pc !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: allowin=%b ex=%b flush=%b eret=%b rfwe=%b fpc=%h, want 1 0 0 0 0 00000000",
                  bus.ws_allowin, wb_ex, ws_flush, eret_flush, ws_rf_we, flush_pc);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_sys();
      csr_eentry = 32'h1C008000;
      csr_era    = 32'h1C000ABC;
      applyStimulus(32'h1C000100, 32'h0, 5'b00100, 1'b0, 1'b1);
      fs_redirect_ack = 1'b1;
      vectors++;
      if (wb_ex !== 1'b1 || wb_ecode !== 6'h0B || wb_esubcode !== 9'd0 ||
          wb_pc !== 32'h1C000100 || ws_flush !== 1'b1 || ws_rf_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sys_commit: ex=%b ecode=%h sub=%h pc=%h flush=%b rfwe=%b, want 1 0b 0 1c000100 1 0",
                  wb_ex, wb_ecode, wb_esubcode, wb_pc, ws_flush, ws_rf_we);
      end
      vectors++;
      if (flush_pc !== 32'h1C008000 || bus.ws_allowin !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL sys_flush_pc: fpc=%h allowin=%b, want 1c008000 1", flush_pc, bus.ws_allowin);
      end
      tick();
      fs_redirect_ack = 1'b0;
      csr_eentry = 32'h1C00F000;
      vectors++;
      if (bus.ws_allowin !== 1'b0 || wb_ex !== 1'b0 || ws_flush !== 1'b0 ||
          flush_pc !== 32'h1C008000) begin
         miscompares++;
         $display("[TB] FAIL sys_wait_same_cycle_ack: allowin=%b ex=%b flush=%b fpc=%h, want 0 0 0 1c008000",
                  bus.ws_allowin, wb_ex, ws_flush, flush_pc);
      end
      tick();
      vectors++;
      if (flush_pc !== 32'h1C008000 || bus.ws_allowin !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sys_wait_hold: fpc=%h allowin=%b, want 1c008000 0", flush_pc, bus.ws_allowin);
      end
      fs_redirect_ack = 1'b1;
      tick();
      fs_redirect_ack = 1'b0;
      vectors++;
      if (bus.ws_allowin !== 1'b1 || flush_pc !== 32'h0 || wb_ex !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sys_after_ack: allowin=%b fpc=%h ex=%b, want 1 00000000 0",
                  bus.ws_allowin, flush_pc, wb_ex);
      end
   endtask

   task automatic test_ale_int();
      csr_eentry      = 32'h1C008000;
      csr_int_pending = 1'b1;
      applyStimulus(32'h1C000300, 32'h00000103, 5'b00001, 1'b0, 1'b1);
      vectors++;
      if (wb_ex !== 1'b1 || wb_ecode !== 6'h00 || wb_vaddr !== 32'h1C000300 ||
          ws_rf_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ale_int_prio: ex=%b ecode=%h vaddr=%h rfwe=%b, want 1 00 1c000300 0",
                  wb_ex, wb_ecode, wb_vaddr, ws_rf_we);
      end
      csr_int_pending = 1'b0;
      finishRedirect();
      csr_eentry = 32'h1C00807F;
      applyStimulus(32'h1C000300, 32'h00000103, 5'b00001, 1'b0, 1'b1);
      vectors++;
      if (wb_ex !== 1'b1 || wb_ecode !== 6'h09 || wb_vaddr !== 32'h00000103 ||
          ws_rf_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ale_plain: ex=%b ecode=%h vaddr=%h rfwe=%b, want 1 09 00000103 0",
                  wb_ex, wb_ecode, wb_vaddr, ws_rf_we);
      end
      vectors++;
      if (flush_pc !== 32'h1C008040) begin
         miscompares++;
         $display("[TB] FAIL eentry_align: fpc=%h, want 1c008040", flush_pc);
      end
      finishRedirect();
      // ADEF outranks INE and SYS
      applyStimulus(32'h1C000310, 32'h0, 5'b11100, 1'b0, 1'b0);
      vectors++;
      if (wb_ecode !== 6'h08 || wb_esubcode !== 9'd0 || wb_ex !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL adef_prio: ecode=%h sub=%h ex=%b, want 08 0 1", wb_ecode, wb_esubcode, wb_ex);
      end
      finishRedirect();
   endtask

   task automatic test_ertn();
      csr_era    = 32'h1C000200;
      csr_eentry = 32'h1C008000;
      applyStimulus(32'h1C000400, 32'h0, 5'b00000, 1'b1, 1'b0);
      vectors++;
      if (eret_flush !== 1'b1 || wb_ex !== 1'b0 || flush_pc !== 32'h1C000200 ||
          ws_flush !== 1'b1 || wb_ecode !== 6'h00) begin
         miscompares++;
         $display("[TB] FAIL ertn_commit: eret=%b ex=%b fpc=%h flush=%b ecode=%h, want 1 0 1c000200 1 00",
                  eret_flush, wb_ex, flush_pc, ws_flush, wb_ecode);
      end
      tick();
      vectors++;
      if (flush_pc !== 32'h1C000200 || eret_flush !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ertn_wait: fpc=%h eret=%b, want 1c000200 0", flush_pc, eret_flush);
      end
      fs_redirect_ack = 1'b1;
      tick();
      fs_redirect_ack = 1'b0;
      applyStimulus(32'h1C000410, 32'h0, 5'b01000, 1'b1, 1'b0);
      vectors++;
      if (wb_ex !== 1'b1 || wb_ecode !== 6'h0D || eret_flush !== 1'b0 ||
          flush_pc !== 32'h1C008000) begin
         miscompares++;
         $display("[TB] FAIL ertn_ine: ex=%b ecode=%h eret=%b fpc=%h, want 1 0d 0 1c008000",
                  wb_ex, wb_ecode, eret_flush, flush_pc);
      end
      finishRedirect();
   endtask

   task automatic test_back_to_back();
      csr_eentry = 32'h1C008000;
      applyStimulus(32'h1C000500, 32'h0, 5'b00010, 1'b0, 1'b0);
      vectors++;
      if (wb_ecode !== 6'h0C || wb_ex !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL brk_commit: ecode=%h ex=%b, want 0c 1", wb_ecode, wb_ex);
      end
      bus.ms_to_ws_valid = 1'b1;
      bus.ms_pc          = 32'h1C000600;
      bus.ms_rf_we       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (bus.ws_allowin !== 1'b0 || ws_rf_we !== 1'b0 || wb_ex !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_wait_%0d: allowin=%b rfwe=%b ex=%b, want 0 0 0",
                     i, bus.ws_allowin, ws_rf_we, wb_ex);
         end
      end
      fs_redirect_ack = 1'b1;
      tick();
      fs_redirect_ack = 1'b0;
      vectors++;
      if (bus.ws_allowin !== 1'b1 || ws_rf_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_ack: allowin=%b rfwe=%b, want 1 0", bus.ws_allowin, ws_rf_we);
      end
      tick();
      clearMs();
      vectors++;
      if (ws_rf_we !== 1'b1 || wb_pc !== 32'h1C000600 || wb_ex !== 1'b0 || ws_flush !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_next_commit: rfwe=%b pc=%h ex=%b flush=%b, want 1 1c000600 0 0",
                  ws_rf_we, wb_pc, wb_ex, ws_flush);
      end
      tick();
      vectors++;
      if (ws_rf_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_valid_clear: rfwe=%b, want 0", ws_rf_we);
      end
   endtask

   task automatic test_reset_in_wait();
      applyStimulus(32'h1C000700, 32'h0, 5'b00100, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (bus.ws_allowin !== 1'b1 || flush_pc !== 32'h0 || wb_ex !== 1'b0 ||
          ws_flush !== 1'b0 || eret_flush !== 1'b0 || ws_rf_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_in_wait: allowin=%b fpc=%h ex=%b flush=%b eret=%b rfwe=%b, want 1 0 0 0 0 0",
                  bus.ws_allowin, flush_pc, wb_ex, ws_flush, eret_flush, ws_rf_we);
      end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      reset           = 1'b1;
      csr_int_pending = 1'b0;
      csr_eentry      = 32'h0;
      csr_era         = 32'h0;
      fs_redirect_ack = 1'b0;
      clearMs();
      test_reset();
      test_sys();
      test_ale_int();
      test_ertn();
      test_back_to_back();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
